// File: rtl/bottle_pkg.sv
// ============================================================================
// Module : bottle_pkg
// Brief  : Shared types, constants and BCD helper for the pill counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bottle_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        SWAP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam bcd_t BCD_MAX = 4'd9;

    // Two-digit BCD increment, wrapping 99 -> 00.
    function automatic logic [7:0] bcd2_inc(input bcd_t hi, input bcd_t lo);
        bcd_t nhi;
        bcd_t nlo;
        nhi = hi;
        nlo = lo + 4'd1;
        if (lo == BCD_MAX) begin
            nlo = 4'd0;
            nhi = (hi == BCD_MAX) ? 4'd0 : hi + 4'd1;
        end
        return {nhi, nlo};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pill_count_if.sv
// ============================================================================
// Module : pill_count_if
// Brief  : Control, setpoint and count bundle of the pill-metering stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pill_count_if;
    import bottle_pkg::*;

    logic EN_work;
    logic EN_set;
    logic isWork;
    bcd_t maxL;
    bcd_t maxH;
    bcd_t tgtL;
    bcd_t tgtH;
    bcd_t nowL;
    bcd_t nowH;
    bcd_t bottleL;
    bcd_t bottleH;
    logic bottle_done;
    logic allFull;
    logic busy;

    modport master (
        output EN_work, EN_set, isWork, maxL, maxH, tgtL, tgtH,
        input  nowL, nowH, bottleL, bottleH, bottle_done, allFull, busy
    );

    modport slave (
        input  EN_work, EN_set, isWork, maxL, maxH, tgtL, tgtH,
        output nowL, nowH, bottleL, bottleH, bottle_done, allFull, busy
    );

endinterface

`default_nettype wire

// File: rtl/bcd2_counter.sv
// ============================================================================
// Module : bcd2_counter
// Brief  : Two-digit BCD register with synchronous clear and enable-increment.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd2_counter
    import bottle_pkg::*;
(
    input  wire  clk,
    input  wire  rst,
    input  wire  clr,
    input  wire  inc,
    output bcd_t lo,
    output bcd_t hi
);

    logic w_carry;

    assign w_carry = (lo == BCD_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo <= 4'd0;
            hi <= 4'd0;
        end else if (clr) begin
            lo <= 4'd0;
            hi <= 4'd0;
        end else if (inc) begin
            if (w_carry) begin
                lo <= 4'd0;
                hi <= (hi == BCD_MAX) ? 4'd0 : hi + 4'd1;
            end else begin
                lo <= lo + 4'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/pill_count.sv
// ============================================================================
// Module : pill_count
// Brief  : Paces pill drops, counts pills per bottle and closed bottles (BCD).
//          Define PILL_SWAP_EN to build the inter-bottle SWAP gap state.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pill_count
    import bottle_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int SWAP_CYCLES = 8
) (
    input  wire          CLK,
    input  wire          RST,
    pill_count_if.slave  bus
);

    localparam int DIV_W = $clog2(TICK_DIV);

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic             r_bottle_done;
    logic             r_all_full;
    logic             r_busy;

    bcd_t             w_now_lo;
    bcd_t             w_now_hi;
    bcd_t             w_bot_lo;
    bcd_t             w_bot_hi;
    logic             w_run;
    logic             w_tick;
    logic             w_fill_tick;
    logic             w_close;
    logic             w_bump;
    logic             w_last;
    logic [7:0]       w_max;
    logic [7:0]       w_now;
    logic [7:0]       w_tgt;
    logic [7:0]       w_next_bottle;

    assign w_run         = !bus.EN_work && bus.isWork && !bus.EN_set;
    assign w_tick        = (r_div == DIV_W'(TICK_DIV - 1));
    assign w_max         = {bus.maxH, bus.maxL};
    assign w_tgt         = {bus.tgtH, bus.tgtL};
    assign w_now         = {w_now_hi, w_now_lo};
    assign w_fill_tick   = (r_state == FILL) && w_run && w_tick;
    // ">=" so a max lowered below the current count still closes on the next tick
    assign w_close       = w_fill_tick && (w_now >= w_max);
    assign w_bump        = w_fill_tick && !w_close;
    assign w_next_bottle = bcd2_inc(w_bot_hi, w_bot_lo);
    assign w_last        = (w_tgt != 8'd0) && (w_next_bottle == w_tgt);

    bcd2_counter u_now (
        .clk (CLK),
        .rst (RST),
        .clr (bus.EN_set || w_close),
        .inc (w_bump),
        .lo  (w_now_lo),
        .hi  (w_now_hi)
    );

    bcd2_counter u_bottle (
        .clk (CLK),
        .rst (RST),
        .clr (bus.EN_set),
        .inc (w_close),
        .lo  (w_bot_lo),
        .hi  (w_bot_hi)
    );

`ifdef PILL_SWAP_EN
    localparam int SW_W = (SWAP_CYCLES > 1) ? $clog2(SWAP_CYCLES) : 1;
    logic [SW_W-1:0] r_swap_cnt;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state       <= IDLE;
            r_div         <= '0;
            r_bottle_done <= 1'b0;
            r_all_full    <= 1'b0;
            r_busy        <= 1'b0;
`ifdef PILL_SWAP_EN
            r_swap_cnt    <= '0;
`endif
        end else begin
            r_bottle_done <= 1'b0;
            if (bus.EN_set) begin
                r_state    <= IDLE;
                r_div      <= '0;
                r_all_full <= 1'b0;
                r_busy     <= 1'b0;
`ifdef PILL_SWAP_EN
                r_swap_cnt <= '0;
`endif
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_run && (w_max != 8'd0)) begin
                            r_state <= FILL;
                            r_div   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    FILL: begin
                        if (w_run) begin
                            if (w_tick) begin
                                r_div <= '0;
                                if (w_close) begin
                                    r_bottle_done <= 1'b1;
                                    if (w_last) begin
                                        r_state    <= DONE;
                                        r_all_full <= 1'b1;
                                        r_busy     <= 1'b0;
                                    end else begin
`ifdef PILL_SWAP_EN
                                        r_state    <= SWAP;
                                        r_swap_cnt <= '0;
`else
                                        r_state    <= FILL;
`endif
                                    end
                                end
                            end else begin
                                r_div <= r_div + DIV_W'(1);
                            end
                        end
                    end
`ifdef PILL_SWAP_EN
                    SWAP: begin
                        if (w_run) begin
                            if (r_swap_cnt == SW_W'(SWAP_CYCLES - 1)) begin
                                r_state    <= FILL;
                                r_div      <= '0;
                                r_swap_cnt <= '0;
                            end else begin
                                r_swap_cnt <= r_swap_cnt + SW_W'(1);
                            end
                        end
                    end
`endif
                    DONE: begin
                        r_all_full <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.nowL        = w_now_lo;
    assign bus.nowH        = w_now_hi;
    assign bus.bottleL     = w_bot_lo;
    assign bus.bottleH     = w_bot_hi;
    assign bus.bottle_done = r_bottle_done;
    assign bus.allFull     = r_all_full;
    assign bus.busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_pill_count.sv
// ============================================================================
// Module : tb_pill_count
// Brief  : Directed, table-driven self-checking bench for pill_count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pill_count;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc;

    always #5 clk = ~clk;

    pill_count_if bus4 ();
    pill_count_if bus2 ();

    pill_count #(.TICK_DIV(4), .SWAP_CYCLES(3)) dut4 (
        .CLK (clk),
        .RST (rst),
        .bus (bus4)
    );

    pill_count #(.TICK_DIV(2), .SWAP_CYCLES(3)) dut2 (
        .CLK (clk),
        .RST (rst),
        .bus (bus2)
    );

    typedef struct {
        int         cycle;
        logic [7:0] now;
        logic [7:0] bot;
        logic       done;
        logic       full;
        logic       busy;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(input int c, input logic [7:0] n, input logic [7:0] b,
                                input logic d, input logic f, input logic bz);
        vec_t v;
        v.cycle = c; v.now = n; v.bot = b; v.done = d; v.full = f; v.busy = bz;
        return v;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus4.EN_work = 1'b0; bus4.EN_set = 1'b0; bus4.isWork = 1'b0;
        bus4.maxL = 4'd0; bus4.maxH = 4'd0; bus4.tgtL = 4'd0; bus4.tgtH = 4'd0;
        bus2.EN_work = 1'b0; bus2.EN_set = 1'b0; bus2.isWork = 1'b0;
        bus2.maxL = 4'd0; bus2.maxH = 4'd0; bus2.tgtL = 4'd0; bus2.tgtH = 4'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cyc = -1;
    endtask

    // Advance to sample point 1 time unit after posedge number c.
    task automatic step_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        vec_t v;

`ifdef PILL_SWAP_EN
        vecs[0]  = mk(0,  8'h00, 8'h00, 0, 0, 1);
        vecs[1]  = mk(4,  8'h01, 8'h00, 0, 0, 1);
        vecs[2]  = mk(12, 8'h03, 8'h00, 0, 0, 1);
        vecs[3]  = mk(16, 8'h00, 8'h01, 1, 0, 1);
        vecs[4]  = mk(17, 8'h00, 8'h01, 0, 0, 1);
        vecs[5]  = mk(19, 8'h00, 8'h01, 0, 0, 1);
        vecs[6]  = mk(22, 8'h00, 8'h01, 0, 0, 1);
        vecs[7]  = mk(23, 8'h01, 8'h01, 0, 0, 1);
        vecs[8]  = mk(31, 8'h03, 8'h01, 0, 0, 1);
        vecs[9]  = mk(34, 8'h03, 8'h01, 0, 0, 1);
        vecs[10] = mk(35, 8'h00, 8'h02, 1, 1, 0);
        vecs[11] = mk(36, 8'h00, 8'h02, 0, 1, 0);
        vecs[12] = mk(40, 8'h00, 8'h02, 0, 1, 0);
`else
        vecs[0]  = mk(0,  8'h00, 8'h00, 0, 0, 1);
        vecs[1]  = mk(3,  8'h00, 8'h00, 0, 0, 1);
        vecs[2]  = mk(4,  8'h01, 8'h00, 0, 0, 1);
        vecs[3]  = mk(8,  8'h02, 8'h00, 0, 0, 1);
        vecs[4]  = mk(12, 8'h03, 8'h00, 0, 0, 1);
        vecs[5]  = mk(15, 8'h03, 8'h00, 0, 0, 1);
        vecs[6]  = mk(16, 8'h00, 8'h01, 1, 0, 1);
        vecs[7]  = mk(17, 8'h00, 8'h01, 0, 0, 1);
        vecs[8]  = mk(20, 8'h01, 8'h01, 0, 0, 1);
        vecs[9]  = mk(31, 8'h03, 8'h01, 0, 0, 1);
        vecs[10] = mk(32, 8'h00, 8'h02, 1, 1, 0);
        vecs[11] = mk(33, 8'h00, 8'h02, 0, 1, 0);
        vecs[12] = mk(40, 8'h00, 8'h02, 0, 1, 0);
`endif

        // Reset state
        clear_inputs();
        do_reset();
        check("reset_now",  {8'h00, bus4.nowH, bus4.nowL}, 16'h0000);
        check("reset_bot",  {8'h00, bus4.bottleH, bus4.bottleL}, 16'h0000);
        check("reset_flags", {13'd0, bus4.bottle_done, bus4.allFull, bus4.busy}, 16'h0000);

        // Main fill sequence: max=03, target=02
        bus4.maxL = 4'd3; bus4.tgtL = 4'd2; bus4.isWork = 1'b1;
        for (int i = 0; i < 13; i++) begin
            v = vecs[i];
            step_to(v.cycle);
            check("seq_now",  {8'h00, bus4.nowH, bus4.nowL}, {8'h00, v.now});
            check("seq_bot",  {8'h00, bus4.bottleH, bus4.bottleL}, {8'h00, v.bot});
            check("seq_done", {15'd0, bus4.bottle_done}, {15'd0, v.done});
            check("seq_full", {15'd0, bus4.allFull}, {15'd0, v.full});
            check("seq_busy", {15'd0, bus4.busy}, {15'd0, v.busy});
        end

        // DONE ignores run; EN_set clears allFull
        @(negedge clk);
        bus4.isWork = 1'b0;
        bus4.EN_set = 1'b1;
        @(posedge clk); #1;
        check("set_from_done_full", {15'd0, bus4.allFull}, 16'd0);
        check("set_from_done_bot",  {8'h00, bus4.bottleH, bus4.bottleL}, 16'h0000);
        bus4.EN_set = 1'b0;

        // BCD carry with TICK_DIV=2, max=12, then a mid-cycle async reset
        do_reset();
        bus2.maxL = 4'd2; bus2.maxH = 4'd1; bus2.isWork = 1'b1;
        for (int c = 0; c <= 30; c++) begin
            step_to(c);
            if (c < 26)
                check("carry_now", {8'h00, bus2.nowH, bus2.nowL}, {8'h00, to_bcd(c / 2)});
            else
                check("carry_now", {8'h00, bus2.nowH, bus2.nowL}, {8'h00, to_bcd((c - 26) / 2)});
            check("carry_digit_valid", {15'd0, (bus2.nowL <= 4'd9)}, 16'd1);
        end
        check("carry_bot", {8'h00, bus2.bottleH, bus2.bottleL}, 16'h0001);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_now",  {8'h00, bus2.nowH, bus2.nowL}, 16'h0000);
        check("async_rst_bot",  {8'h00, bus2.bottleH, bus2.bottleL}, 16'h0000);
        check("async_rst_busy", {15'd0, bus2.busy}, 16'd0);

        // Pause: drop isWork for 5 cycles at divider=2
        do_reset();
        bus4.maxL = 4'd5; bus4.isWork = 1'b1;
        step_to(2);
        @(negedge clk);
        bus4.isWork = 1'b0;
        step_to(7);
        check("pause_now",  {8'h00, bus4.nowH, bus4.nowL}, 16'h0000);
        check("pause_busy", {15'd0, bus4.busy}, 16'd1);
        @(negedge clk);
        bus4.isWork = 1'b1;
        step_to(8);
        check("pause_now_before", {8'h00, bus4.nowH, bus4.nowL}, 16'h0000);
        step_to(9);
        check("pause_now_after",  {8'h00, bus4.nowH, bus4.nowL}, 16'h0001);

        // EN_set while now=02, bottle=01
        do_reset();
        bus4.maxL = 4'd3; bus4.isWork = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            step_to(cyc + 1);
            if (bus4.nowL == 4'd2 && bus4.nowH == 4'd0 && bus4.bottleL == 4'd1)
                found = 1'b1;
        end
        check("set_wait_found", {15'd0, found}, 16'd1);
        bus4.EN_set = 1'b1;
        step_to(cyc + 1);
        check("set_now",   {8'h00, bus4.nowH, bus4.nowL}, 16'h0000);
        check("set_bot",   {8'h00, bus4.bottleH, bus4.bottleL}, 16'h0000);
        check("set_flags", {13'd0, bus4.bottle_done, bus4.allFull, bus4.busy}, 16'h0000);
        @(negedge clk);
        bus4.EN_set = 1'b0;

        // max=00 with run stays idle
        do_reset();
        bus4.isWork = 1'b1;
        step_to(10);
        check("max0_busy", {15'd0, bus4.busy}, 16'd0);
        check("max0_now",  {8'h00, bus4.nowH, bus4.nowL}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
